// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: widths, ALU op codes, FSM encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [OP_W-1:0] OP_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL = 3'd3;
    localparam logic [OP_W-1:0] OP_DIV = 3'd4;
    localparam logic [OP_W-1:0] OP_SLL = 3'd5;
    localparam logic [OP_W-1:0] OP_SUB = 3'd6;
    localparam logic [OP_W-1:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Multiply is given its own multicycle allowance; everything else shares one.
    function automatic logic [CNT_W-1:0] exec_cycles(input logic [OP_W-1:0] op,
                                                     input int unsigned mul_c,
                                                     input int unsigned alu_c);
        return (op == OP_MUL) ? CNT_W'(mul_c) : CNT_W'(alu_c);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-request round-robin grant; the pointer flips to the other port on every accept.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_gnt_id,
    output logic       o_gnt_valid
);

    logic r_ptr;
    logic w_gnt_id;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        w_gnt_id = i_req[1];
        if (i_req == 2'b11) begin
            w_gnt_id = r_ptr;
        end
    end

    assign o_gnt_id    = w_gnt_id;
    assign o_gnt_valid = |i_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~w_gnt_id;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Optional grant counters are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = alu_pkg::DATA_W,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned ALU_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]       grant0_cnt,
    output logic [15:0]       grant1_cnt
`endif
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_gnt;

    logic              w_gnt_id;
    logic              w_gnt_valid;
    logic              w_accept;
    logic              w_rsp_ack;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [OP_W-1:0]   w_sel_op;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .i_req       ({req1_valid, req0_valid}),
        .i_accept    (w_accept),
        .o_gnt_id    (w_gnt_id),
        .o_gnt_valid (w_gnt_valid)
    );

    // Ready is a same-cycle acknowledge, so it is only offered while idle.
    assign w_accept   = (r_state == IDLE) && !reset && w_gnt_valid;
    assign req0_ready = w_accept && !w_gnt_id;
    assign req1_ready = w_accept &&  w_gnt_id;

    assign w_sel_a   = w_gnt_id ? req1_a  : req0_a;
    assign w_sel_b   = w_gnt_id ? req1_b  : req0_b;
    assign w_sel_op  = w_gnt_id ? req1_op : req0_op;
    assign w_rsp_ack = r_gnt ? rsp1_ready : rsp0_ready;

    // The operand registers double as the ALU drive: cleared when idle, held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_gnt      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        alu_a    <= w_sel_a;
                        alu_b    <= w_sel_b;
                        alu_ctrl <= w_sel_op;
                        r_gnt    <= w_gnt_id;
                        r_cnt    <= exec_cycles(w_sel_op, MUL_CYCLES, ALU_CYCLES);
                        busy     <= 1'b1;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        rsp_data   <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp0_valid <= !r_gnt;
                        rsp1_valid <=  r_gnt;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (w_rsp_ack) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        alu_ctrl   <= '0;
                        busy       <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    // Saturating per-port accept counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (req0_ready && (grant0_cnt != 16'hFFFF)) begin
                grant0_cnt <= grant0_cnt + 16'd1;
            end
            if (req1_ready && (grant1_cnt != 16'hFFFF)) begin
                grant1_cnt <= grant1_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model and a bench-side ALU.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned MUL_N = 2;
    localparam int unsigned ALU_N = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        busy;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] grant0_cnt, grant1_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc[2];
    int gq[$];

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a * b;
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd5: return a << b[4:0];
            3'd6: return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);
    assign alu_zero   = (alu_result == 32'd0);

    wire [104:0] all_out = {req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
                            rsp0_valid, rsp1_valid, rsp_data, rsp_zero, busy};

    alu_arbiter #(.DATA_W(32), .MUL_CYCLES(MUL_N), .ALU_CYCLES(ALU_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
`ifdef ALU_ARB_PERF_EN
        ,
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
    endtask

    // Reference model: one outstanding transaction, timed from its accept cycle.
    bit          m_active = 0;
    int          m_acc = 0, m_n = 0, m_port = 0, m_ptr = 0;
    logic [31:0] m_a = '0, m_b = '0, m_last = '0;
    logic [2:0]  m_op = '0;
    logic        m_last_z = 1'b0;
    int          m_g0 = 0, m_g1 = 0;

    always @(negedge clk) begin : model
        bit          ev;
        int          eid;
        logic [31:0] er;
        if (reset) begin
            check("reset_outputs", all_out, 0);
`ifdef ALU_ARB_PERF_EN
            check("reset_perf", {grant1_cnt, grant0_cnt}, 0);
            m_g0 = 0;
            m_g1 = 0;
`endif
            m_active = 0;
            m_ptr    = 0;
            m_last   = '0;
            m_last_z = 1'b0;
        end else begin
`ifdef ALU_ARB_PERF_EN
            check("perf_cnt", {grant1_cnt, grant0_cnt}, {m_g1[15:0], m_g0[15:0]});
`endif
            if (!m_active) begin
                ev  = req0_valid || req1_valid;
                eid = (req0_valid && req1_valid) ? m_ptr : (req1_valid ? 1 : 0);
                check("idle_ready", {req1_ready, req0_ready},
                      {ev && (eid == 1), ev && (eid == 0)});
                check("idle_out", {busy, rsp1_valid, rsp0_valid, alu_a, alu_b, alu_ctrl}, 0);
                check("idle_rsp_hold", {rsp_zero, rsp_data}, {m_last_z, m_last});
                if (ev) begin
                    m_active = 1;
                    m_acc    = cyc;
                    m_port   = eid;
                    m_a      = (eid == 1) ? req1_a : req0_a;
                    m_b      = (eid == 1) ? req1_b : req0_b;
                    m_op     = (eid == 1) ? req1_op : req0_op;
                    m_n      = (m_op == 3'd3) ? MUL_N : ALU_N;
                    m_ptr    = 1 - eid;
                    gq.push_back(eid);
                    if (eid == 0 && m_g0 < 65535) m_g0++;
                    if (eid == 1 && m_g1 < 65535) m_g1++;
                end
            end else if (cyc <= m_acc + m_n) begin
                check("exec_ctrl", {busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 5'b10000);
                check("exec_operands", {alu_a, alu_b, alu_ctrl}, {m_a, m_b, m_op});
            end else begin
                er = alu_f(m_a, m_b, m_op);
                check("resp_ctrl", {busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready},
                      {1'b1, m_port == 1, m_port == 0, 2'b00});
                check("resp_operands", {alu_a, alu_b, alu_ctrl}, {m_a, m_b, m_op});
                check("resp_data", {rsp_zero, rsp_data}, {er == 32'd0, er});
                if ((m_port == 0) ? rsp0_ready : rsp1_ready) begin
                    m_active = 0;
                    m_last   = er;
                    m_last_z = (er == 32'd0);
                end
            end
        end
    end

    // Raises valid on one port and returns on the cycle after it is accepted.
    task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
        bit got = 0;
        if (p == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin
                got = 1;
                acc_cyc[p] = cyc;
            end
        end
        if (!got) timeout("accept");
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int p, output int at, output int ctrl_hits,
                            input logic [2:0] want_ctrl);
        bit got = 0;
        at = -1;
        ctrl_hits = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? rsp0_valid : rsp1_valid) begin
                got = 1;
                at  = cyc;
            end else if (alu_ctrl == want_ctrl) begin
                ctrl_hits++;
            end
        end
        if (!got) timeout("response");
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        if (!got) timeout("idle");
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_async", all_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int at, hits;
        int exp_order[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        logic [31:0] t0_a[4] = '{32'hFF00_FF00, 32'd100, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] t0_b[4] = '{32'h0F0F_0F0F, 32'd7, 32'd31, 32'd1};
        logic [2:0]  t0_o[4] = '{OP_AND, OP_DIV, OP_SLL, OP_SLT};
        logic [31:0] t1_a[4] = '{32'h1234_0000, 32'd7, 32'd3, 32'd5};
        logic [31:0] t1_b[4] = '{32'h0000_5678, 32'd6, 32'd5, 32'd0};
        logic [2:0]  t1_o[4] = '{OP_OR, OP_MUL, OP_SUB, OP_DIV};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // ADD on port 0
        @(posedge clk);
        #1;
        send(0, 32'd5, 32'd7, OP_ADD);
        wait_rsp(0, at, hits, OP_ADD);
        check("add_latency", at - acc_cyc[0], 2);
        check("add_result", {rsp_zero, rsp_data}, {1'b0, 32'd12});
        @(negedge clk);
        check("add_busy_low", busy, 1'b0);

        // MUL on port 1, two EXEC cycles
        @(posedge clk);
        #1;
        send(1, 32'hFFFF_FFFD, 32'd4, OP_MUL);
        wait_rsp(1, at, hits, OP_MUL);
        check("mul_latency", at - acc_cyc[1], 3);
        check("mul_ctrl_cycles", hits, 2);
        check("mul_result", rsp_data, 32'hFFFF_FFF4);
        check("mul_rsp0_quiet", rsp0_valid, 1'b0);
        wait_idle();

        // Both ports contend with four requests each
        @(posedge clk);
        #1;
        gq.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, t0_a[i], t0_b[i], t0_o[i]);
            end
            begin
                for (int i = 0; i < 4; i++) send(1, t1_a[i], t1_b[i], t1_o[i]);
            end
        join
        wait_idle();
        check("rr_count", gq.size(), 8);
        for (int i = 0; i < 8 && i < gq.size(); i++) check("rr_order", gq[i], exp_order[i]);

        // Backpressure on port 0 while port 1 waits
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        send(0, 32'd9, 32'd9, OP_SUB);
        req1_valid = 1'b1; req1_a = 32'd11; req1_b = 32'd4; req1_op = OP_ADD;
        wait_rsp(0, at, hits, OP_SUB);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {rsp0_valid, rsp_zero, rsp_data}, {1'b1, 1'b1, 32'd0});
            check("bp_req1_wait", req1_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_ack_cycle_no_grant", {rsp0_valid, req1_ready}, 2'b10);
        @(negedge clk);
        check("bp_grant_after_ack", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_idle();

        // Reset mid-EXEC of port 1
        @(posedge clk);
        #1;
        send(1, 32'd10, 32'd20, OP_MUL);
        reset = 1'b1;
        #1;
        check("rst_exec_outputs", all_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_AND;
        @(negedge clk);
        check("rst_exec_first_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Reset mid-RESP with the pointer on port 1
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        send(0, 32'd1, 32'd2, OP_ADD);
        wait_rsp(0, at, hits, OP_ADD);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_resp_outputs", all_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("rst_resp_first_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Lone requester repeatedly, then one port 1 grant
        pulse_reset();
        send(0, 32'd3, 32'd4, OP_ADD);
        send(0, 32'd8, 32'd8, OP_SUB);
        send(0, 32'd6, 32'd2, OP_SLL);
        send(1, 32'd2, 32'd3, OP_OR);
        wait_idle();
        check("lone_last_data", rsp_data, 32'd3);
`ifdef ALU_ARB_PERF_EN
        check("perf_grant0", grant0_cnt, 16'd3);
        check("perf_grant1", grant1_cnt, 16'd1);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters, e.g. the integer pipeline (port 0) and a multi-cycle/debug unit (port 1).
- Uses round-robin arbitration with a valid/ready request handshake per port.
- Holds the operands stable to the ALU for a programmable number of cycles. Multiply gets a multicycle-path allowance.
- Registers the result and zero flag, then returns them to the granted requester with a valid/ready response handshake.

Parameters:
- DATA_W, 32, operand/result width.
- MUL_CYCLES, 2, EXEC cycles for op 3'b011 (multiply). Legal range 1..15.
- ALU_CYCLES, 1, EXEC cycles for every other op. Legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a, req0_b  in  DATA_W  port 0 operands.
- req0_op  in  3  port 0 ALU_Control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as port 0, for port 1.
- alu_a, alu_b  out  DATA_W  operands to the ALU.
- alu_ctrl  out  3  ALU_Control to the ALU.
- alu_result  in  DATA_W  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp0_valid, rsp1_valid  out  1  response valid, per port.
- rsp0_ready, rsp1_ready  in  1  response consumed, per port.
- rsp_data  out  DATA_W  registered result, shared by both ports.
- rsp_zero  out  1  registered zero flag, shared by both ports.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; the round-robin pointer ptr is 0 (port 0 has priority).
  - Operand/op latches and the cycle counter are 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant port ptr.
  - reqN_ready is high, combinationally, only for the granted port and only in IDLE. It is never high in EXEC or RESP.
  - On the accept edge, latch a, b and op plus the grant id; set ptr to the other port; load cnt with MUL_CYCLES if op==3'b011, else ALU_CYCLES; go to EXEC.
- EXEC:
  - alu_a, alu_b and alu_ctrl are driven from the latches. They are 0 in IDLE and hold their values through RESP.
  - cnt decrements each cycle.
  - On the last cycle (cnt==1), register alu_result into rsp_data and alu_zero into rsp_zero, then go to RESP.
- RESP:
  - rsp<grant>_valid is high; the other port's rsp valid stays 0.
  - rsp_data and rsp_zero stay stable until rsp<grant>_ready is high, then go to IDLE.
  - rsp_data keeps its last value afterwards.
- Latency: if accept occurs in cycle k, EXEC occupies cycles k+1..k+N and rsp valid is high from cycle k+N+1. With ready tied high, the next accept is possible in cycle k+N+2.
- Arithmetic: the arbiter is transparent and never alters data. All 8 op codes pass through, including 3'b100, whose result is whatever the ALU drives.
- Boundary cases:
  - A requester dropping valid before it is granted is legal; nothing is recorded.
  - A request arriving during EXEC/RESP waits; no queueing beyond the holding requester.
  - Back-to-back requests from both ports alternate strictly: 0,1,0,1.
  - A single persistent requester is granted every turn; ptr still toggles, but a lone valid always wins.
  - rspN_ready while rspN_valid is low is ignored.
  - reset mid-EXEC or mid-RESP aborts immediately: the in-flight op is dropped, no response is issued, and ptr returns to 0.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined: adds outputs grant0_cnt and grant1_cnt (16 bits each).
  - Each increments on its port's accept edge and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the ALU op codes: OP_AND=0, OP_OR=1, OP_ADD=2, OP_MUL=3, OP_DIV=4, OP_SLL=5, OP_SUB=6, OP_SLT=7;
  - the FSM state encoding: IDLE=0, EXEC=1, RESP=2;
  - DATA_W.
- Natural sub-module: rr_arb2, a 2-request round-robin grant with pointer register, outputs grant id and grant valid. The FSM, counter and latches live in alu_arbiter.
- The ALU is instantiated at the parent level, not inside alu_arbiter.

Test Plan:
- Port 0 sends ADD a=5 b=7; rsp0_ready is high; the bench ALU model is connected. Expected: rsp0_valid rises 2 cycles after accept; rsp_data=12, rsp_zero=0, busy low 1 cycle later.
- Port 1 sends MUL a=-3 b=4 with MUL_CYCLES=2. Expected: alu_ctrl=3 held for 2 EXEC cycles; rsp1_valid 3 cycles after accept; rsp_data=32'hFFFFFFF4.
- Both ports hold valid with 4 requests each. Expected grant order 0,1,0,1,...; no grant while busy; each response appears only on its own rspN_valid.
- rsp0_ready is held low 5 cycles after SUB a=9 b=9. Expected: rsp0_valid, rsp_data=0 and rsp_zero=1 stay stable; req1 is not accepted until the cycle after rsp0_ready.
- reset is asserted mid-EXEC of a port 1 request. Expected: all outputs 0 immediately, no rsp1_valid; after release, simultaneous requests grant port 0 first.
- With ALU_ARB_PERF_EN defined, 3 grants to port 0 and 1 to port 1. Expected: grant0_cnt=3, grant1_cnt=1.
